// File: rtl/ram_sequencer_if.sv
// Request/handshake bundle between a RAM sequencer and its clients plus the shared RAM port.
// Signal names follow the established engine-side naming of the original S-RAM mux.
interface ram_sequencer_if #(
   parameter int NUM_DEVICES = 3,
   parameter int RAM_WIDTH   = 8,
   parameter int ADDR_WIDTH  = 8
);
   localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;

   logic                              go;
   logic                              run_all;
   logic [DEV_W-1:0]                  sel;
   logic                              abort;

   logic [NUM_DEVICES-1:0]            start_bus;
   logic [NUM_DEVICES-1:0]            finish_bus;
   logic [NUM_DEVICES-1:0]            sWrenBus;
   logic [NUM_DEVICES*RAM_WIDTH-1:0]  sInBus;
   logic [NUM_DEVICES*ADDR_WIDTH-1:0] sAddrBus;

   logic                              sWren;
   logic [RAM_WIDTH-1:0]              sIn;
   logic [ADDR_WIDTH-1:0]             sAddr;

   logic                              busy;
   logic                              done;
   logic                              timeout_err;
   logic [DEV_W-1:0]                  active_dev;

   modport slave (
      input  go, run_all, sel, abort,
      input  finish_bus, sWrenBus, sInBus, sAddrBus,
      output start_bus, sWren, sIn, sAddr,
      output busy, done, timeout_err, active_dev
   );

   modport master (
      output go, run_all, sel, abort,
      output finish_bus, sWrenBus, sInBus, sAddrBus,
      input  start_bus, sWren, sIn, sAddr,
      input  busy, done, timeout_err, active_dev
   );
endinterface

// File: rtl/ram_sequencer.sv
// Multi-device RAM access sequencer: grants a shared single-port RAM to one client
// engine at a time, either a single selected engine or all engines in index order.
//
// state  | meaning
// -------+----------------------------------------------------------------
// IDLE   | waiting for an accepted go; all outputs quiet
// ACTIVE | granted device started and owns the RAM port; watchdog counting
// GAP    | one quiet cycle between devices so each returns to idle
// DONE   | one-cycle completion pulse
module ram_sequencer #(
   parameter int NUM_DEVICES    = 3,
   parameter int RAM_WIDTH      = 8,
   parameter int ADDR_WIDTH     = 8,
   parameter int TIMEOUT_CYCLES = 0
) (
   input logic            clk,
   input logic            reset,
   ram_sequencer_if.slave bus
);
   localparam int DEV_W = (NUM_DEVICES > 1) ? $clog2(NUM_DEVICES) : 1;
   localparam int CNT_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;
   localparam logic [DEV_W-1:0] DEV_LAST = DEV_W'(NUM_DEVICES - 1);
   localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

   typedef enum logic [1:0] {IDLE, ACTIVE, GAP, DONE} state_t;

   state_t           state, state_nxt;
   logic [DEV_W-1:0] grant;
   logic             mode_all;
   logic [CNT_W-1:0] cnt;
   logic             terr;

   logic             accept;
   logic             advance;
   logic             wd_fire;
   logic             sel_ok;
   logic             fin_granted;
   logic             last_dev;
   logic             wd_hit;

   assign sel_ok      = int'(bus.sel) < NUM_DEVICES;
   assign fin_granted = bus.finish_bus[grant];
   assign last_dev    = !mode_all || (grant == DEV_LAST);
   assign wd_hit      = (TIMEOUT_CYCLES > 0) && (cnt == CNT_LAST);

   // State register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state decode; abort outranks finish, finish outranks the watchdog
   always_comb begin
      state_nxt = state;
      accept    = 1'b0;
      advance   = 1'b0;
      wd_fire   = 1'b0;
      case (state)
         IDLE: begin
            if (bus.go && (bus.run_all || sel_ok)) begin
               accept    = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         ACTIVE: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else if (fin_granted) begin
               state_nxt = last_dev ? DONE : GAP;
            end else if (wd_hit) begin
               wd_fire   = 1'b1;
               state_nxt = IDLE;
            end
         end
         GAP: begin
            if (bus.abort) begin
               state_nxt = IDLE;
            end else begin
               advance   = 1'b1;
               state_nxt = ACTIVE;
            end
         end
         DONE: state_nxt = IDLE;
         default: state_nxt = IDLE;
      endcase
   end

   // Grant index and latched mode; grant only ever moves forward, never wraps
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         grant    <= '0;
         mode_all <= 1'b0;
      end else if (accept) begin
         grant    <= bus.run_all ? '0 : bus.sel;
         mode_all <= bus.run_all;
      end else if (advance) begin
         grant    <= grant + DEV_W'(1);
      end
   end

   // Watchdog: counts ACTIVE cycles of the current device, saturates, clears elsewhere
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)                                  cnt <= '0;
      else if (state != ACTIVE)                    cnt <= '0;
      else if (cnt != {CNT_W{1'b1}})               cnt <= cnt + CNT_W'(1);
   end

   // Sticky timeout flag, cleared when the next operation is accepted
   always_ff @(posedge clk or negedge reset) begin
      if (!reset)       terr <= 1'b0;
      else if (accept)  terr <= 1'b0;
      else if (wd_fire) terr <= 1'b1;
   end

   // Status and start decode from registered state only
   always_comb begin
      bus.start_bus   = (state == ACTIVE) ? (NUM_DEVICES'(1) << grant) : '0;
      bus.busy        = (state != IDLE);
      bus.done        = (state == DONE);
      bus.timeout_err = terr;
      bus.active_dev  = grant;
   end

   // RAM port mux: combinational from the grant so client requests see no added latency
   always_comb begin
      bus.sWren = 1'b0;
      bus.sIn   = '0;
      bus.sAddr = '0;
      if (state == ACTIVE) begin
         bus.sWren = bus.sWrenBus[grant];
         bus.sIn   = bus.sInBus[int'(grant)*RAM_WIDTH +: RAM_WIDTH];
         bus.sAddr = bus.sAddrBus[int'(grant)*ADDR_WIDTH +: ADDR_WIDTH];
      end
   end
endmodule

// File: tb/tb_ram_sequencer.sv
// Self-checking bench for ram_sequencer: per-cycle expected outputs are queued when
// stimulus is driven and compared against the DUT one cycle later.
module tb_ram_sequencer;
   logic clk;
   logic reset;

   logic [2:0]  wren_bus;
   logic [23:0] in_bus;
   logic [23:0] addr_bus;

   int checks = 0;
   int errors = 0;

   typedef struct packed {
      logic [2:0] start;
      logic       busy;
      logic       done;
      logic [1:0] dev;
      logic       terr;
      logic       wren;
      logic [7:0] din;
      logic [7:0] addr;
   } exp_t;

   exp_t sb[$];

   ram_sequencer_if #(.NUM_DEVICES(3), .RAM_WIDTH(8), .ADDR_WIDTH(8)) sif ();
   ram_sequencer_if #(.NUM_DEVICES(3), .RAM_WIDTH(8), .ADDR_WIDTH(8)) wif ();

   ram_sequencer #(.NUM_DEVICES(3), .RAM_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(0)) dut (
      .clk(clk), .reset(reset), .bus(sif));
   ram_sequencer #(.NUM_DEVICES(3), .RAM_WIDTH(8), .ADDR_WIDTH(8), .TIMEOUT_CYCLES(8)) dut_wd (
      .clk(clk), .reset(reset), .bus(wif));

   assign sif.sWrenBus = wren_bus;
   assign sif.sInBus   = in_bus;
   assign sif.sAddrBus = addr_bus;
   assign wif.sWrenBus = wren_bus;
   assign wif.sInBus   = in_bus;
   assign wif.sAddrBus = addr_bus;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation still running at %0t, required finish earlier", $time);
      $fatal(1, "bench time limit expired");
   end

   // Expected outputs for a given one-hot start; RAM outputs follow the started device
   function automatic exp_t mk_exp(logic [2:0] st, logic bsy, logic dn, logic [1:0] dv, logic te);
      exp_t e;
      e.start = st; e.busy = bsy; e.done = dn; e.dev = dv; e.terr = te;
      e.wren = 1'b0; e.din = '0; e.addr = '0;
      for (int i = 0; i < 3; i++) begin
         if (st[i]) begin
            e.wren = wren_bus[i];
            e.din  = in_bus[i*8 +: 8];
            e.addr = addr_bus[i*8 +: 8];
         end
      end
      return e;
   endfunction

   function automatic exp_t obs_main();
      exp_t o;
      o.start = sif.start_bus; o.busy = sif.busy; o.done = sif.done; o.dev = sif.active_dev;
      o.terr = sif.timeout_err; o.wren = sif.sWren; o.din = sif.sIn; o.addr = sif.sAddr;
      return o;
   endfunction

   function automatic exp_t obs_wd();
      exp_t o;
      o.start = wif.start_bus; o.busy = wif.busy; o.done = wif.done; o.dev = wif.active_dev;
      o.terr = wif.timeout_err; o.wren = wif.sWren; o.din = wif.sIn; o.addr = wif.sAddr;
      return o;
   endfunction

   function automatic string fmt(exp_t e);
      return $sformatf("start=%b busy=%b done=%b dev=%0d terr=%b wren=%b din=%h addr=%h",
                       e.start, e.busy, e.done, e.dev, e.terr, e.wren, e.din, e.addr);
   endfunction

   task automatic new_bus();
      wren_bus = 3'($urandom);
      in_bus   = 24'($urandom);
      addr_bus = 24'($urandom);
   endtask

   task automatic clear_inputs();
      sif.go = 1'b0; sif.run_all = 1'b0; sif.sel = 2'd0; sif.abort = 1'b0; sif.finish_bus = 3'b000;
      wif.go = 1'b0; wif.run_all = 1'b0; wif.sel = 2'd0; wif.abort = 1'b0; wif.finish_bus = 3'b000;
   endtask

   task automatic test_reset();
      exp_t e, o;
      clear_inputs();
      new_bus();
      reset = 1'b0;
      repeat (3) @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      new_bus();
      #1;
      e = mk_exp(3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
      o = obs_main();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_main: got %s, want %s", fmt(o), fmt(e));
      end
      o = obs_wd();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL reset_wd: got %s, want %s", fmt(o), fmt(e));
      end
   endtask

   // Device 1 alone for 10 cycles; a go with sel=2 mid-run must be ignored
   task automatic test_single();
      exp_t e, o;
      int k;
      sb.delete();
      for (int c = 0; c <= 13; c++) begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front(); o = obs_main(); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL single cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
            end
         end
         sif.go         = (c == 0 || c == 5);
         sif.run_all    = 1'b0;
         sif.sel        = (c == 5) ? 2'd2 : 2'd1;
         sif.finish_bus = (c == 10) ? 3'b010 : 3'b000;
         new_bus();
         k = c + 1;
         if (k <= 10)      sb.push_back(mk_exp(3'b010, 1'b1, 1'b0, 2'd1, 1'b0));
         else if (k == 11) sb.push_back(mk_exp(3'b000, 1'b1, 1'b1, 2'd1, 1'b0));
         else              sb.push_back(mk_exp(3'b000, 1'b0, 1'b0, 2'd1, 1'b0));
      end
   endtask

   // All three devices (4, 6, 5 cycles) with a stray finish[2] while device 0 runs
   task automatic test_run_all();
      exp_t e, o;
      int k;
      sb.delete();
      for (int c = 0; c <= 20; c++) begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front(); o = obs_main(); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL run_all cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
            end
         end
         sif.go      = (c == 0);
         sif.run_all = 1'b1;
         sif.sel     = 2'd1;
         case (c)
            2:       sif.finish_bus = 3'b100;
            4:       sif.finish_bus = 3'b001;
            11:      sif.finish_bus = 3'b010;
            17:      sif.finish_bus = 3'b100;
            default: sif.finish_bus = 3'b000;
         endcase
         new_bus();
         k = c + 1;
         if (k <= 4)       sb.push_back(mk_exp(3'b001, 1'b1, 1'b0, 2'd0, 1'b0));
         else if (k == 5)  sb.push_back(mk_exp(3'b000, 1'b1, 1'b0, 2'd0, 1'b0));
         else if (k <= 11) sb.push_back(mk_exp(3'b010, 1'b1, 1'b0, 2'd1, 1'b0));
         else if (k == 12) sb.push_back(mk_exp(3'b000, 1'b1, 1'b0, 2'd1, 1'b0));
         else if (k <= 17) sb.push_back(mk_exp(3'b100, 1'b1, 1'b0, 2'd2, 1'b0));
         else if (k == 18) sb.push_back(mk_exp(3'b000, 1'b1, 1'b1, 2'd2, 1'b0));
         else              sb.push_back(mk_exp(3'b000, 1'b0, 1'b0, 2'd2, 1'b0));
      end
   endtask

   // Abort arrives together with device 1's finish: straight to IDLE, no done, no device 2
   task automatic test_abort();
      exp_t e, o;
      int k;
      sb.delete();
      for (int c = 0; c <= 12; c++) begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front(); o = obs_main(); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL abort cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
            end
         end
         sif.go         = (c == 0);
         sif.run_all    = 1'b1;
         sif.abort      = (c == 7);
         sif.finish_bus = (c == 4) ? 3'b001 : ((c == 7) ? 3'b010 : 3'b000);
         new_bus();
         k = c + 1;
         if (k <= 4)      sb.push_back(mk_exp(3'b001, 1'b1, 1'b0, 2'd0, 1'b0));
         else if (k == 5) sb.push_back(mk_exp(3'b000, 1'b1, 1'b0, 2'd0, 1'b0));
         else if (k <= 7) sb.push_back(mk_exp(3'b010, 1'b1, 1'b0, 2'd1, 1'b0));
         else             sb.push_back(mk_exp(3'b000, 1'b0, 1'b0, 2'd1, 1'b0));
      end
      sif.abort = 1'b0;
   endtask

   // go with an out-of-range sel must leave the sequencer idle
   task automatic test_illegal();
      exp_t e, o;
      sb.delete();
      for (int c = 0; c <= 5; c++) begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front(); o = obs_main(); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL illegal_sel cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
            end
         end
         sif.go = 1'b1; sif.run_all = 1'b0; sif.sel = 2'd3; sif.finish_bus = 3'b000;
         new_bus();
         sb.push_back(mk_exp(3'b000, 1'b0, 1'b0, 2'd1, 1'b0));
      end
      sif.go = 1'b0;
   endtask

   // TIMEOUT_CYCLES=8: device 0 never finishes, flag sticks until the next accepted go
   task automatic test_watchdog();
      exp_t e, o;
      int k;
      sb.delete();
      for (int c = 0; c <= 16; c++) begin
         @(negedge clk);
         if (sb.size() != 0) begin
            e = sb.pop_front(); o = obs_wd(); checks++;
            if (o !== e) begin
               errors++;
               $display("FAIL watchdog cycle %0d: got %s, want %s", c, fmt(o), fmt(e));
            end
         end
         wif.go         = (c == 0 || c == 12);
         wif.run_all    = 1'b0;
         wif.sel        = (c == 12) ? 2'd2 : 2'd0;
         wif.finish_bus = (c == 13) ? 3'b100 : 3'b000;
         new_bus();
         k = c + 1;
         if (k <= 8)       sb.push_back(mk_exp(3'b001, 1'b1, 1'b0, 2'd0, 1'b0));
         else if (k <= 12) sb.push_back(mk_exp(3'b000, 1'b0, 1'b0, 2'd0, 1'b1));
         else if (k == 13) sb.push_back(mk_exp(3'b100, 1'b1, 1'b0, 2'd2, 1'b0));
         else if (k == 14) sb.push_back(mk_exp(3'b000, 1'b1, 1'b1, 2'd2, 1'b0));
         else              sb.push_back(mk_exp(3'b000, 1'b0, 1'b0, 2'd2, 1'b0));
      end
   endtask

   // Reset asserted mid-ACTIVE, away from any clock edge
   task automatic test_async_reset();
      exp_t e, o;
      clear_inputs();
      @(negedge clk);
      sif.go = 1'b1; sif.sel = 2'd0;
      @(negedge clk);
      sif.go = 1'b0;
      new_bus();
      wren_bus = 3'b111;
      @(negedge clk);
      e = mk_exp(3'b001, 1'b1, 1'b0, 2'd0, 1'b0);
      o = obs_main();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL pre_reset_active: got %s, want %s", fmt(o), fmt(e));
      end
      #2;
      reset = 1'b0;
      #1;
      e = mk_exp(3'b000, 1'b0, 1'b0, 2'd0, 1'b0);
      o = obs_main();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL async_reset: got %s, want %s", fmt(o), fmt(e));
      end
      @(negedge clk);
      reset = 1'b1;
      @(negedge clk);
      @(negedge clk);
      o = obs_main();
      checks++;
      if (o !== e) begin
         errors++;
         $display("FAIL after_reset_release: got %s, want %s", fmt(o), fmt(e));
      end
   endtask

   initial begin
      reset = 1'b0;
      test_reset();
      test_single();
      test_run_all();
      test_abort();
      test_illegal();
      clear_inputs();
      test_watchdog();
      test_async_reset();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
